// File: rtl/lut_reverse_search.sv
// rtl/lut_reverse_search.sv - key/data table with a sequential reverse (data -> key) search
//
// Purpose:
//   Holds NR_KEY {key, data, valid} entries. A search request carries a data
//   value. The block scans the entries one per cycle, starting at index 0, and
//   returns the key and index of the lowest valid entry whose data matches.
//   The table can be written in any cycle, including while a search runs.
//
// Ports:
//   clk, rst         rising-edge clock; synchronous active-high reset
//   wr_en/wr_idx/    single-entry table write (key, data and valid bit);
//   wr_vld/wr_key/   an index >= NR_KEY is dropped
//   wr_data
//   lut, vld_mask    table contents straight from the entry registers
//   s_valid/s_ready/ search request handshake plus the data value to find
//   s_data
//   r_valid/r_ready  response handshake; r_hit/r_key/r_idx are held until
//   r_hit/r_key/     the response is taken
//   r_idx

module lut_reverse_search #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8,
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
  localparam int IDX_W    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic                         wr_vld,
  input  logic [KEY_LEN-1:0]           wr_key,
  input  logic [DATA_LEN-1:0]          wr_data,

  output logic [NR_KEY*PAIR_LEN-1:0]   lut,
  output logic [NR_KEY-1:0]            vld_mask,

  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_LEN-1:0]          s_data,

  output logic                         r_valid,
  input  logic                         r_ready,
  output logic                         r_hit,
  output logic [KEY_LEN-1:0]           r_key,
  output logic [IDX_W-1:0]             r_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, next_state;

  logic [KEY_LEN-1:0]  keys  [NR_KEY];
  logic [DATA_LEN-1:0] datas [NR_KEY];

  logic [DATA_LEN-1:0] cap_data;
  logic [IDX_W-1:0]    ptr;
  logic                match;
  logic                wr_in_range;

  // Indices past the last entry exist only when NR_KEY is not a power of two.
  assign wr_in_range = (int'(wr_idx) < NR_KEY);

  // Table registers. Writes are independent of the search FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NR_KEY; n++) begin
        keys[n]  <= '0;
        datas[n] <= '0;
      end
      vld_mask <= '0;
    end else if (wr_en && wr_in_range) begin
      keys[wr_idx]     <= wr_key;
      datas[wr_idx]    <= wr_data;
      vld_mask[wr_idx] <= wr_vld;
    end
  end

  always_comb begin
    lut = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      lut[n*PAIR_LEN +: PAIR_LEN] = {keys[n], datas[n]};
    end
  end

  // Compares against the registered entry, so a write landing on the same
  // edge the entry is evaluated is not seen by this scan.
  assign match = vld_mask[ptr] && (datas[ptr] == cap_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    r_valid    = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) next_state = SCAN;
      end
      SCAN: begin
        if (match || (ptr == LAST_IDX)) next_state = RESP;
      end
      RESP: begin
        r_valid = 1'b1;
        if (r_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Scan pointer, captured search value and the held response. The response
  // registers load only when a scan finishes, so table writes during RESP
  // leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data <= '0;
      ptr      <= '0;
      r_hit    <= 1'b0;
      r_key    <= '0;
      r_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            cap_data <= s_data;
            ptr      <= '0;
          end
        end
        SCAN: begin
          if (match) begin
            r_hit <= 1'b1;
            r_key <= keys[ptr];
            r_idx <= ptr;
          end else if (ptr == LAST_IDX) begin
            r_hit <= 1'b0;
            r_key <= '0;
            r_idx <= '0;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_reverse_search.sv
// tb/tb_lut_reverse_search.sv - directed self-checking bench for lut_reverse_search

module tb_lut_reverse_search;

  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 2;
  localparam int DATA_LEN = 8;
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
  localparam int IDX_W    = 2;
  localparam int MAX_WAIT = 50;

  logic                       clk;
  logic                       rst;
  logic                       wr_en;
  logic [IDX_W-1:0]           wr_idx;
  logic                       wr_vld;
  logic [KEY_LEN-1:0]         wr_key;
  logic [DATA_LEN-1:0]        wr_data;
  logic [NR_KEY*PAIR_LEN-1:0] lut;
  logic [NR_KEY-1:0]          vld_mask;
  logic                       s_valid;
  logic                       s_ready;
  logic [DATA_LEN-1:0]        s_data;
  logic                       r_valid;
  logic                       r_ready;
  logic                       r_hit;
  logic [KEY_LEN-1:0]         r_key;
  logic [IDX_W-1:0]           r_idx;

  int n_checks = 0;
  int n_fail   = 0;

  lut_reverse_search #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_vld  (wr_vld),
    .wr_key  (wr_key),
    .wr_data (wr_data),
    .lut     (lut),
    .vld_mask(vld_mask),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_hit   (r_hit),
    .r_key   (r_key),
    .r_idx   (r_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic vld, input int key, input int data);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(idx);
    wr_vld  = vld;
    wr_key  = KEY_LEN'(key);
    wr_data = DATA_LEN'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  // Issues one search and waits for r_valid. Edge count includes the accept
  // edge. When wr_at >= 0, a table write is driven in the cycle after edge
  // wr_at, so it lands on edge wr_at+1.
  task automatic search(input string tag, input int data,
                        input logic want_hit, input int want_key, input int want_idx,
                        input int want_lat,
                        input int wr_at, input int w_idx, input int w_key, input int w_data);
    int lat;
    check({tag, "_s_ready_before"}, 64'(s_ready), 64'(1));
    s_valid = 1'b1;
    s_data  = DATA_LEN'(data);
    lat = 0;
    do begin
      tick();
      lat++;
      s_valid = 1'b0;
      if (lat == wr_at) begin
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(w_idx);
        wr_vld  = 1'b1;
        wr_key  = KEY_LEN'(w_key);
        wr_data = DATA_LEN'(w_data);
      end else begin
        wr_en = 1'b0;
      end
    end while (!r_valid && lat < MAX_WAIT);
    wr_en = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(want_lat));
    check({tag, "_hit"}, 64'(r_hit), 64'(want_hit));
    check({tag, "_key"}, 64'(r_key), 64'(want_key));
    check({tag, "_idx"}, 64'(r_idx), 64'(want_idx));
  endtask

  task automatic release_resp(input string tag);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check({tag, "_idle_s_ready"}, 64'(s_ready), 64'(1));
    check({tag, "_idle_r_valid"}, 64'(r_valid), 64'(0));
  endtask

  initial begin
    logic [NR_KEY*PAIR_LEN-1:0] exp_lut;
    int rv_seen;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_vld  = 1'b0;
    wr_key  = '0;
    wr_data = '0;
    s_valid = 1'b0;
    s_data  = '0;
    r_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_lut", 64'(lut), 64'(0));
    check("reset_vld_mask", 64'(vld_mask), 64'(0));
    check("reset_s_ready", 64'(s_ready), 64'(1));
    check("reset_r_valid", 64'(r_valid), 64'(0));

    wr(0, 1'b1, 3, 8'h10);
    wr(1, 1'b1, 2, 8'h20);
    wr(2, 1'b1, 1, 8'h30);
    wr(3, 1'b1, 0, 8'h20);
    exp_lut = {2'd0, 8'h20, 2'd1, 8'h30, 2'd2, 8'h20, 2'd3, 8'h10};
    check("table_lut", 64'(lut), 64'(exp_lut));
    check("table_vld_mask", 64'(vld_mask), 64'(4'hf));

    // Lowest matching index wins (entries 1 and 3 both hold 0x20).
    search("hit_0x20", 8'h20, 1'b1, 2, 1, 3, -1, 0, 0, 0);
    release_resp("hit_0x20");

    search("miss_0x55", 8'h55, 1'b0, 0, 0, 5, -1, 0, 0, 0);
    release_resp("miss_0x55");

    wr(1, 1'b0, 2, 8'h20);
    check("inval_vld_mask", 64'(vld_mask), 64'(4'hd));
    search("inval_0x20", 8'h20, 1'b1, 0, 3, 5, -1, 0, 0, 0);
    release_resp("inval_0x20");

    // Hold the response while rewriting the matched entry.
    search("hold_0x10", 8'h10, 1'b1, 3, 0, 2, -1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      wr(0, 1'b1, 1, 8'h77 + c);
      check("hold_r_valid", 64'(r_valid), 64'(1));
      check("hold_r_hit", 64'(r_hit), 64'(1));
      check("hold_r_key", 64'(r_key), 64'(3));
      check("hold_r_idx", 64'(r_idx), 64'(0));
      check("hold_s_ready", 64'(s_ready), 64'(0));
    end
    check("hold_entry0_rewritten", 64'(lut[PAIR_LEN-1:0]), 64'({2'd1, 8'h79}));
    release_resp("hold_0x10");

    // Entry ahead of the pointer written during the scan is found.
    search("ahead_0x99", 8'h99, 1'b1, 2, 3, 5, 1, 3, 2, 8'h99);
    release_resp("ahead_0x99");

    // Entry 0 written on the very edge it is evaluated is not seen.
    search("behind_0x88", 8'h88, 1'b0, 0, 0, 5, 1, 0, 3, 8'h88);
    release_resp("behind_0x88");
    check("behind_entry0", 64'(lut[PAIR_LEN-1:0]), 64'({2'd3, 8'h88}));

    // Abort a search with reset mid-scan (0x30 would hit at index 2).
    check("abort_s_ready_before", 64'(s_ready), 64'(1));
    s_valid = 1'b1;
    s_data  = 8'h30;
    tick();
    s_valid = 1'b0;
    tick();
    check("abort_mid_scan_s_ready", 64'(s_ready), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_s_ready", 64'(s_ready), 64'(1));
    check("abort_r_valid", 64'(r_valid), 64'(0));
    check("abort_vld_mask", 64'(vld_mask), 64'(0));
    check("abort_lut", 64'(lut), 64'(0));
    check("abort_r_hit", 64'(r_hit), 64'(0));
    rv_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (r_valid) rv_seen++;
    end
    check("abort_no_response", 64'(rv_seen), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_reverse_search.md
LUT_REVERSE_SEARCH -- requirements
Module: lut_reverse_search

Interface
REQ-001 The block SHALL have parameter NR_KEY, default 4, meaning the number of table entries (>=2).
REQ-002 The block SHALL have parameter KEY_LEN, default 2, meaning the key width in bits.
REQ-003 The block SHALL have parameter DATA_LEN, default 8, meaning the data width in bits; PAIR_LEN=KEY_LEN+DATA_LEN and IDX_W=max(1,clog2(NR_KEY)) are derived.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  write one table entry this cycle.
REQ-007 wr_idx  input  IDX_W  entry index to write.
REQ-008 wr_vld  input  1  new valid bit for the written entry (0 = invalidate).
REQ-009 wr_key  input  KEY_LEN  key to store.
REQ-010 wr_data  input  DATA_LEN  data to store.
REQ-011 lut  output  NR_KEY*PAIR_LEN  packed table; entry n at bits [PAIR_LEN*(n+1)-1:PAIR_LEN*n], key in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
REQ-012 vld_mask  output  NR_KEY  per-entry valid bits.
REQ-013 s_valid  input  1  search request valid.
REQ-014 s_ready  output  1  block accepts a search request.
REQ-015 s_data  input  DATA_LEN  data value to reverse-look-up.
REQ-016 r_valid  output  1  response valid.
REQ-017 r_ready  input  1  consumer accepts the response.
REQ-018 r_hit  output  1  a valid entry matched.
REQ-019 r_key  output  KEY_LEN  key of the matching entry (0 on miss).
REQ-020 r_idx  output  IDX_W  index of the matching entry (0 on miss).

Function
REQ-021 Table write SHALL occur on the rising edge when wr_en=1; entry wr_idx key/data/valid update; wr_idx>=NR_KEY SHALL be ignored.
REQ-022 Writes SHALL be accepted in every state, including during a search.
REQ-023 The FSM SHALL have states IDLE, SCAN, RESP; s_ready=1 only in IDLE; r_valid=1 only in RESP.
REQ-024 IDLE -> SCAN on s_valid&&s_ready; s_data SHALL be captured into an internal register at that edge; the scan pointer SHALL be set to 0.
REQ-025 In SCAN the block SHALL compare one entry per cycle, entry[ptr], against the captured data, using the registered table contents of that cycle (a same-cycle write to entry[ptr] is not seen).
REQ-026 SCAN -> RESP with r_hit=1, r_key=entry key, r_idx=ptr when entry[ptr] is valid and its data equals the captured data; the lowest matching index SHALL win.
REQ-027 SCAN -> RESP with r_hit=0, r_key=0, r_idx=0 when ptr=NR_KEY-1 and there is no match; otherwise ptr increments.
REQ-028 Latency: a match at index i SHALL assert r_valid i+2 cycles after the accept edge; a miss SHALL assert it NR_KEY+1 cycles after.
REQ-029 RESP SHALL hold r_valid/r_hit/r_key/r_idx stable until r_valid&&r_ready; at that edge the FSM SHALL go to IDLE.
REQ-030 A write that changes the matched entry while in RESP SHALL NOT alter the held response.
REQ-031 Entries written before the scan pointer reaches them SHALL be seen by the scan; entries already passed SHALL NOT be rescanned.
REQ-032 lut and vld_mask SHALL be driven directly from the table registers (no extra latency beyond the write edge).

Reset
REQ-033 With rst=1 at a rising edge, all entries SHALL clear to key=0, data=0, valid=0; the FSM SHALL go to IDLE; r_valid, r_hit, r_key, r_idx SHALL be 0; s_ready SHALL be 1 after the edge.
REQ-034 rst SHALL take priority over wr_en and over any search in progress; an aborted search SHALL produce no response.

Verification
REQ-035 Reset, then check lut=0, vld_mask=0, s_ready=1, r_valid=0.
REQ-036 Write entries 0..3 = (key 3,data 0x10),(2,0x20),(1,0x30),(0,0x20); search 0x20 -> r_hit=1, r_key=2, r_idx=1, r_valid 3 cycles after accept.
REQ-037 Same table, search 0x55 -> r_hit=0, r_key=0, r_idx=0, r_valid 5 cycles after accept.
REQ-038 Invalidate entry 1 (wr_vld=0), search 0x20 -> r_hit=1, r_idx=3, r_key=0.
REQ-039 Hold r_ready=0 for 3 cycles in RESP while rewriting the matched entry -> response stable and s_ready=0 throughout; IDLE one edge after r_ready=1.
REQ-040 Assert rst mid-SCAN -> next cycle s_ready=1, r_valid=0, vld_mask=0; no response ever appears for the aborted search.
